// File: rtl/button_pulse_conditioner.sv
// Two-button debouncer feeding seq_detector_mealy: each press becomes one clean, mutually exclusive P1/P2 pulse.
// Optional auto-repeat while a button is held is enabled by defining BTN_AUTOREPEAT_EN.
module button_pulse_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_RATE     = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn1_raw,
   input  logic btn2_raw,
   output logic P1,
   output logic P2,
   output logic conflict
);

   localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
   localparam int CW     = $clog2(MAX_P) + 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_DELAY - 1);
   // Reloading here makes the next hit of REP_LAST exactly REPEAT_RATE cycles later.
   localparam logic [CW-1:0] REP_RELOAD = CW'(REPEAT_DELAY - REPEAT_RATE);
`endif

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ARM_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   logic [1:0] meta_q, meta_d;
   logic [1:0] sync_q, sync_d;
   logic [1:0] q_q, q_d;
   logic       p1_q, p1_d;
   logic       p2_q, p2_d;
   logic       conflict_q, conflict_d;

   always_comb begin
      meta_d = {btn2_raw, btn1_raw};
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          press;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            IDLE: begin
               if (sync_q[gi]) begin
                  state_d = ARM_PRESS;
                  cnt_d   = CW'(1);
               end
            end
            ARM_PRESS: begin
               if (!sync_q[gi]) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            PRESSED: begin
               if (!sync_q[gi]) begin
                  state_d = ARM_RELEASE;
                  cnt_d   = CW'(1);
               end
            end
            ARM_RELEASE: begin
               // A bounce back to high resumes the held press without a new pulse.
               if (sync_q[gi]) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

`ifdef BTN_AUTOREPEAT_EN
      logic [CW-1:0] rep_q, rep_d;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            rep_q <= '0;
         end else begin
            rep_q <= rep_d;
         end
      end

      always_comb begin
         rep_d = '0;
         if (state_q == PRESSED && sync_q[gi]) begin
            rep_d = (rep_q == REP_LAST) ? REP_RELOAD : rep_q + CW'(1);
         end
      end

      always_comb begin
         press = (state_q == ARM_PRESS && sync_q[gi] && cnt_q == CNT_LAST) ||
                 (state_q == PRESSED && sync_q[gi] && rep_q == REP_LAST);
      end
`else
      always_comb begin
         press = (state_q == ARM_PRESS && sync_q[gi] && cnt_q == CNT_LAST);
      end
`endif

      assign q_d[gi] = press;
   end

   // Simultaneous qualification drops both pulses rather than picking a winner.
   always_comb begin
      p1_d       = q_q[0] & ~q_q[1];
      p2_d       = q_q[1] & ~q_q[0];
      conflict_d = q_q[0] & q_q[1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q        <= '0;
         p1_q       <= 1'b0;
         p2_q       <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         q_q        <= q_d;
         p1_q       <= p1_d;
         p2_q       <= p2_d;
         conflict_q <= conflict_d;
      end
   end

   assign P1       = p1_q;
   assign P2       = p2_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Self-checking bench for button_pulse_conditioner: a press table plus bounce, sequence,
// adjacent-pulse and reset-mid-press sequences, all checked cycle by cycle against a scoreboard.
module tb_button_pulse_conditioner;
   localparam int DEB = 4;
   localparam int RD  = 8;
   localparam int RR  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn1_raw = 1'b0;
   logic btn2_raw = 1'b0;
   logic P1, P2, conflict;

   button_pulse_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE(RR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btn1_raw(btn1_raw),
      .btn2_raw(btn2_raw),
      .P1(P1),
      .P2(P2),
      .conflict(conflict)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int   cyc;
      logic p1;
      logic p2;
      logic cf;
   } exp_t;

   typedef struct {
      logic b1;
      logic b2;
      int   hold;
      logic e1;
      logic e2;
      logic ec;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;

   // Every cycle the outputs must equal the scoreboard entry due now, or all zero.
   always @(negedge clk) begin
      logic e1, e2, ec;
      if (mon_en) begin
         e1 = 1'b0;
         e2 = 1'b0;
         ec = 1'b0;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e1 = sb[0].p1;
            e2 = sb[0].p2;
            ec = sb[0].cf;
            void'(sb.pop_front());
         end
         checks++;
         if ({P1, P2, conflict} !== {e1, e2, ec}) begin
            failures++;
            $display("FAIL pulse_out cyc=%0d got P1=%b P2=%b conflict=%b expected P1=%b P2=%b conflict=%b",
                     cyc, P1, P2, conflict, e1, e2, ec);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raw level driven at the negedge after posedge n, held h cycles.
   task automatic push_press(input int n, input int h, input logic e1, input logic e2, input logic ec);
      exp_t r;
      int   e;
      if (e1 | e2 | ec) begin
         r.p1  = e1;
         r.p2  = e2;
         r.cf  = ec;
         r.cyc = n + DEB + 3;
         sb.push_back(r);
`ifdef BTN_AUTOREPEAT_EN
         e = n + DEB + 2 + RD;
         while (e <= n + h + 2) begin
            r.cyc = e + 1;
            sb.push_back(r);
            e += RR;
         end
`else
         e = h;
`endif
      end
   endtask

   task automatic press(input logic b1, input logic b2, input int h,
                        input logic e1, input logic e2, input logic ec);
      @(negedge clk);
      btn1_raw = b1;
      btn2_raw = b2;
      push_press(cyc, h, e1, e2, ec);
      $display("press b1=%b b2=%b hold=%0d at cyc=%0d", b1, b2, h, cyc);
      repeat (h) @(negedge clk);
      btn1_raw = 1'b0;
      btn2_raw = 1'b0;
      idle(DEB + 10);
   endtask

   vec_t vecs[8];
   int   seq[8];

   initial begin
      vecs[0] = '{1'b1, 1'b0, 20,  1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 20,  1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 20,  1'b0, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 2,   1'b0, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, DEB - 1, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b0, DEB, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 1'b1, DEB, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, DEB, 1'b0, 1'b0, 1'b1};
      seq = '{1, 2, 2, 1, 2, 2, 1, 2};

      mon_en = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(10);

      for (int i = 0; i < 8; i++) begin
         press(vecs[i].b1, vecs[i].b2, vecs[i].hold, vecs[i].e1, vecs[i].e2, vecs[i].ec);
      end

      // Bounce on button 2: 1,0,1,0 then steady high.
      @(negedge clk) btn2_raw = 1'b1;
      @(negedge clk) btn2_raw = 1'b0;
      @(negedge clk) btn2_raw = 1'b1;
      @(negedge clk) btn2_raw = 1'b0;
      @(negedge clk) btn2_raw = 1'b1;
      push_press(cyc, 20, 1'b0, 1'b1, 1'b0);
      $display("bounce final rise at cyc=%0d", cyc);
      idle(20);
      btn2_raw = 1'b0;
      idle(DEB + 10);

      // Symbol sequence 1,2,2,1,2,2,1,2 spaced 10 cycles apart.
      for (int i = 0; i < 8; i++) begin
         if (seq[i] == 1) btn1_raw = 1'b1;
         else             btn2_raw = 1'b1;
         push_press(cyc, DEB, seq[i] == 1, seq[i] == 2, 1'b0);
         $display("seq symbol %0d at cyc=%0d", seq[i], cyc);
         idle(DEB);
         btn1_raw = 1'b0;
         btn2_raw = 1'b0;
         idle(10 - DEB);
      end
      idle(DEB + 10);

      // Different buttons one cycle apart: pulses on adjacent cycles.
      btn1_raw = 1'b1;
      push_press(cyc, DEB, 1'b1, 1'b0, 1'b0);
      @(negedge clk) btn2_raw = 1'b1;
      push_press(cyc, DEB, 1'b0, 1'b1, 1'b0);
      $display("adjacent presses at cyc=%0d", cyc);
      idle(DEB - 1);
      btn1_raw = 1'b0;
      @(negedge clk) btn2_raw = 1'b0;
      idle(DEB + 10);

      // Reset while ARM_PRESS cnt=2, button held across reset release.
      btn1_raw = 1'b1;
      idle(4);
      reset = 1'b1;
      $display("reset asserted mid-press at cyc=%0d", cyc);
      idle(3);
      reset = 1'b0;
      push_press(cyc, 20, 1'b1, 1'b0, 1'b0);
      $display("reset released at cyc=%0d", cyc);
      idle(20);
      btn1_raw = 1'b0;
      idle(DEB + 10);

      idle(20);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain pending=%0d expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
